// File: rtl/vga_timing_gen_if.sv
// Video timing bus: raster position, syncs, display enable and strobes.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 12
);
  logic [CNT_W-1:0]   hpos;
  logic [CNT_W-1:0]   vpos;
  logic               de_early;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output hpos, vpos, de_early, hsync, vsync, de,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  hpos, vpos, de_early, hsync, vsync, de,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel enable, sync polarity control and a
// sync/DE delay line so syncs stay aligned with a pixel pipeline of any depth
// from 1 to 8 enabled pixels.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_BOTTOM   = 10,
  parameter int V_SYNC     = 2,
  parameter int V_TOP      = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int PIPE_DEPTH = 0,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  vga_timing_gen_if.master   vif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  // Region bounds held 32 bits wide so the upper bounds cannot alias when a
  // porch is zero and the bound lands exactly on 2^CNT_W.
  localparam logic [31:0] HD_END   = 32'(H_DISPLAY);
  localparam logic [31:0] VD_END   = 32'(V_DISPLAY);
  localparam logic [31:0] HS_START = 32'(H_DISPLAY + H_FRONT);
  localparam logic [31:0] HS_END   = 32'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_DISPLAY + V_BOTTOM);
  localparam logic [31:0] VS_END   = 32'(V_DISPLAY + V_BOTTOM + V_SYNC);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Reject configurations the counters or delay line cannot represent.
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DEPTH must be 0..7");
  end
  if (CNT_W < 1 || CNT_W > 30 ||
      (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cnt
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (FRAME_W < 1) begin : g_bad_frame
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic [FRAME_W-1:0] f_cnt;
  sync_t              s0;
  sync_t [PIPE_DEPTH:0] dly_pipe;

  // Raster counters: column wraps into line, line wraps into frame count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      f_cnt <= '0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
          f_cnt <= f_cnt + 1'b1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Undelayed sync/DE decode from the current raster position. vs0 depends
  // only on the line, so after the delay line it toggles in column 0.
  always_comb begin
    s0    = '0;
    s0.hs = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    s0.vs = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    s0.de = (32'(h_cnt) < HD_END) && (32'(v_cnt) < VD_END);
  end

  // Delay line: one stage minimum, PIPE_DEPTH extra; cleared on reset so no
  // partial sync pulse survives a mid-frame restart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_pipe <= '0;
    end else if (ce) begin
      dly_pipe[0] <= s0;
      for (int i = 1; i <= PIPE_DEPTH; i++) begin
        dly_pipe[i] <= dly_pipe[i-1];
      end
    end
  end

  // Output drive: polarity applied at the last stage; strobes are gated by ce.
  always_comb begin
    vif.hpos        = h_cnt;
    vif.vpos        = v_cnt;
    vif.frame_count = f_cnt;
    vif.de_early    = s0.de;
    vif.hsync       = (H_SYNC_POL != 0) ? dly_pipe[PIPE_DEPTH].hs : ~dly_pipe[PIPE_DEPTH].hs;
    vif.vsync       = (V_SYNC_POL != 0) ? dly_pipe[PIPE_DEPTH].vs : ~dly_pipe[PIPE_DEPTH].vs;
    vif.de          = dly_pipe[PIPE_DEPTH].de;
    vif.line_start  = ce && (h_cnt == '0);
    vif.frame_start = ce && (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small-timing,
// deep-pipe, narrow-frame-counter instance share clock, reset and ce. Both are
// compared against a raster model computed from the enabled-pixel count.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(12)) if_a ();
  vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2))  if_b ();

  vga_timing_gen dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .vif   (if_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
    .H_SYNC_POL(1), .V_SYNC_POL(0), .PIPE_DEPTH(3),
    .CNT_W(4), .FRAME_W(2)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .vif   (if_b)
  );

  typedef struct {
    int hd, hf, hs, hb, vd, vb, vs, vt, pd, fw, hpol, vpol;
  } tm_t;

  tm_t tm_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 12, 0, 0};
  tm_t tm_b = '{8, 2, 2, 2, 4, 1, 1, 1, 3, 2, 1, 0};

  int n = 0;            // enabled pixels since the last reset
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [63:0] pack(input int hp, input int vp, input int fc,
                                       input logic dee, input logic hs, input logic vs,
                                       input logic de, input logic ls, input logic fs);
    return {16'(hp), 16'(vp), 16'(fc), 10'd0, dee, hs, vs, de, ls, fs};
  endfunction

  // Raster state after k enabled pixels; delayed outputs show the raster
  // position pd+1 pixels earlier, or idle if that is before the reset.
  function automatic logic [63:0] model(input tm_t t, input int k, input logic cev);
    int ht, vt, hp, vp, m, mh, mv, fc;
    logic hsa, vsa, dea, dee, ls;
    ht  = t.hd + t.hf + t.hs + t.hb;
    vt  = t.vd + t.vb + t.vs + t.vt;
    hp  = k % ht;
    vp  = (k / ht) % vt;
    fc  = (k / (ht * vt)) % (1 << t.fw);
    dee = (hp < t.hd) && (vp < t.vd);
    ls  = cev && (hp == 0);
    hsa = 1'b0;
    vsa = 1'b0;
    dea = 1'b0;
    if (k >= t.pd + 1) begin
      m   = k - t.pd - 1;
      mh  = m % ht;
      mv  = (m / ht) % vt;
      hsa = (mh >= t.hd + t.hf) && (mh < t.hd + t.hf + t.hs);
      vsa = (mv >= t.vd + t.vb) && (mv < t.vd + t.vb + t.vs);
      dea = (mh < t.hd) && (mv < t.vd);
    end
    return pack(hp, vp, fc, dee, (t.hpol != 0) ? hsa : !hsa,
                (t.vpol != 0) ? vsa : !vsa, dea, ls, ls && (vp == 0));
  endfunction

  function automatic logic [63:0] obs_a();
    return pack(int'(if_a.hpos), int'(if_a.vpos), int'(if_a.frame_count), if_a.de_early,
                if_a.hsync, if_a.vsync, if_a.de, if_a.line_start, if_a.frame_start);
  endfunction

  function automatic logic [63:0] obs_b();
    return pack(int'(if_b.hpos), int'(if_b.vpos), int'(if_b.frame_count), if_b.de_early,
                if_b.hsync, if_b.vsync, if_b.de, if_b.line_start, if_b.frame_start);
  endfunction

  // Drive ce/rst_n, take one clock edge, track the pixel count, settle at negedge.
  task automatic step(input logic cev, input logic rstv);
    ce    = cev;
    rst_n = rstv;
    @(posedge clk);
    if (!rstv)    n = 0;
    else if (cev) n = n + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] o, e;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    o = obs_a(); e = model(tm_a, n, 1'b1);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset_a got %h want %h", o, e);
    end
    o = obs_b(); e = model(tm_b, n, 1'b1);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset_b got %h want %h", o, e);
    end
    vectors++;
    if (if_a.hsync !== 1'b1 || if_a.vsync !== 1'b1 || if_a.de !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a_idle got hs=%b vs=%b de=%b want 1 1 0", if_a.hsync, if_a.vsync, if_a.de);
    end
    vectors++;
    if (if_b.hsync !== 1'b0 || if_b.vsync !== 1'b1 || if_b.de !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b_idle got hs=%b vs=%b de=%b want 0 1 0", if_b.hsync, if_b.vsync, if_b.de);
    end
  endtask

  // ce held high: full compare every pixel plus hsync timing and DE counts.
  task automatic test_free_run();
    logic [63:0] o, e;
    logic prev;
    int falls[$];
    int rises[$];
    int de_a, de_b;
    de_a = 0;
    de_b = 0;
    step(1'b1, 1'b0);
    prev = if_a.hsync;
    for (int c = 0; c < 1700; c++) begin
      step(1'b1, 1'b1);
      o = obs_a(); e = model(tm_a, n, 1'b1);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL free_run_a n=%0d got %h want %h", n, o, e);
      end
      o = obs_b(); e = model(tm_b, n, 1'b1);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL free_run_b n=%0d got %h want %h", n, o, e);
      end
      if (prev === 1'b1 && if_a.hsync === 1'b0) falls.push_back(n);
      if (prev === 1'b0 && if_a.hsync === 1'b1) rises.push_back(n);
      prev = if_a.hsync;
      if (n >= 1 && n <= 800 && if_a.de === 1'b1) de_a++;
      if (n >= 4 && n <= 17 && if_b.de === 1'b1) de_b++;
    end
    vectors++;
    if (falls.size() < 2 || rises.size() < 1) begin
      miscompares++;
      $display("FAIL hsync_edges got falls=%0d rises=%0d want >=2 >=1", falls.size(), rises.size());
    end else begin
      vectors++;
      if (falls[0] != 657) begin
        miscompares++;
        $display("FAIL first_hsync_fall got %0d want 657", falls[0]);
      end
      vectors++;
      if (falls[1] - falls[0] != 800) begin
        miscompares++;
        $display("FAIL hsync_period got %0d want 800", falls[1] - falls[0]);
      end
      vectors++;
      if (rises[0] - falls[0] != 96) begin
        miscompares++;
        $display("FAIL hsync_width got %0d want 96", rises[0] - falls[0]);
      end
    end
    vectors++;
    if (de_a != 640) begin
      miscompares++;
      $display("FAIL de_per_line_a got %0d want 640", de_a);
    end
    vectors++;
    if (de_b != 8) begin
      miscompares++;
      $display("FAIL de_per_line_b got %0d want 8", de_b);
    end
  endtask

  // ce alternating 1,0: periods measured in clocks double.
  task automatic test_ce_toggle();
    logic [63:0] o, e;
    logic prev, cev;
    int falls[$];
    int rises[$];
    step(1'b1, 1'b0);
    prev = if_a.hsync;
    for (int c = 0; c < 3400; c++) begin
      cev = (c % 2 == 0);
      step(cev, 1'b1);
      o = obs_a(); e = model(tm_a, n, cev);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL ce_toggle_a n=%0d got %h want %h", n, o, e);
      end
      o = obs_b(); e = model(tm_b, n, cev);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL ce_toggle_b n=%0d got %h want %h", n, o, e);
      end
      vectors++;
      if ((if_a.line_start === 1'b1 || if_b.line_start === 1'b1) && !cev) begin
        miscompares++;
        $display("FAIL line_start_ce0 c=%0d got a=%b b=%b want 0 0", c, if_a.line_start, if_b.line_start);
      end
      if (prev === 1'b1 && if_a.hsync === 1'b0) falls.push_back(c);
      if (prev === 1'b0 && if_a.hsync === 1'b1) rises.push_back(c);
      prev = if_a.hsync;
    end
    vectors++;
    if (falls.size() < 2 || rises.size() < 1) begin
      miscompares++;
      $display("FAIL ce_hsync_edges got falls=%0d rises=%0d want >=2 >=1", falls.size(), rises.size());
    end else begin
      vectors++;
      if (falls[1] - falls[0] != 1600) begin
        miscompares++;
        $display("FAIL ce_hsync_period got %0d want 1600", falls[1] - falls[0]);
      end
      vectors++;
      if (rises[0] - falls[0] != 192) begin
        miscompares++;
        $display("FAIL ce_hsync_width got %0d want 192", rises[0] - falls[0]);
      end
    end
  endtask

  // Random ce; frame counter of the narrow instance must wrap 0,1,2,3,0.
  task automatic test_random_ce();
    logic [63:0] o, e;
    logic cev;
    int fcq[$];
    step(1'b1, 1'b0);
    if (if_b.frame_start === 1'b1) fcq.push_back(int'(if_b.frame_count));
    for (int c = 0; c < 3000; c++) begin
      cev = ($urandom_range(0, 3) != 0);
      step(cev, 1'b1);
      o = obs_a(); e = model(tm_a, n, cev);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random_ce_a n=%0d got %h want %h", n, o, e);
      end
      o = obs_b(); e = model(tm_b, n, cev);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random_ce_b n=%0d got %h want %h", n, o, e);
      end
      if (if_b.frame_start === 1'b1) fcq.push_back(int'(if_b.frame_count));
    end
    vectors++;
    if (fcq.size() < 5) begin
      miscompares++;
      $display("FAIL frame_start_count got %0d want >=5", fcq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (fcq[k] != k % 4) begin
          miscompares++;
          $display("FAIL frame_count_seq k=%0d got %0d want %0d", k, fcq[k], k % 4);
        end
      end
    end
  endtask

  // Reset inside an active hsync pulse (with ce low), then check a clean restart.
  task automatic test_mid_reset();
    logic [63:0] o, e;
    logic prev;
    int first_fall;
    bit found;
    found = 1'b0;
    for (int g = 0; g < 1000; g++) begin
      if (n % 800 == 700) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b1);
    end
    vectors++;
    if (!found || if_a.hsync !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_setup got found=%0d hsync=%b want 1 0", found, if_a.hsync);
    end
    step(1'b0, 1'b0);
    o = obs_a(); e = model(tm_a, n, 1'b0);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL mid_reset_a got %h want %h", o, e);
    end
    o = obs_b(); e = model(tm_b, n, 1'b0);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL mid_reset_b got %h want %h", o, e);
    end
    vectors++;
    if (if_a.hpos !== 10'd0 || if_a.vpos !== 10'd0 || if_a.frame_count !== 12'd0 ||
        if_a.hsync !== 1'b1 || if_a.de !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_state got h=%0d v=%0d f=%0d hs=%b de=%b want 0 0 0 1 0",
               if_a.hpos, if_a.vpos, if_a.frame_count, if_a.hsync, if_a.de);
    end
    prev = if_a.hsync;
    first_fall = -1;
    for (int c = 0; c < 1000; c++) begin
      step(1'b1, 1'b1);
      if (prev === 1'b1 && if_a.hsync === 1'b0) begin
        first_fall = n;
        break;
      end
      prev = if_a.hsync;
    end
    vectors++;
    if (first_fall != 657) begin
      miscompares++;
      $display("FAIL restart_hsync_fall got %0d want 657", first_fall);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_free_run();
    test_ce_toggle();
    test_random_ce();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
